// File: rtl/sdram_frame_sequencer.sv
// Burst sequencer between the pixel FIFOs and the SDRAM controller command port.
// Arbitrates write/read bursts and rotates 1-3 frame buffers at frame boundaries.
module sdram_frame_sequencer #(
  parameter int ADDR_W      = 25,
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN   = 256,
  parameter int NUM_BUFS    = 2,
  parameter int BASE_ADDR   = 0,
  parameter int BUF_STRIDE  = 524288,
  parameter int LEVEL_W     = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [LEVEL_W-1:0]           wr_level,
  input  logic [LEVEL_W-1:0]           rd_space,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic                         cmd_write,
  output logic [ADDR_W-1:0]            cmd_addr,
  output logic [$clog2(BURST_LEN):0]   cmd_len,
  input  logic                         burst_done,
  output logic                         wr_frame_done,
  output logic                         rd_frame_start,
  output logic [1:0]                   wr_buf,
  output logic [1:0]                   rd_buf,
  output logic                         busy
);
  localparam int LEN_W = $clog2(BURST_LEN) + 1;
  localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;

  logic [OFF_W-1:0] wr_off, rd_off;
  logic [1:0]       latest;
  logic             ready, wr_hold, last_wr;
  logic [LEN_W-1:0] wr_need, rd_need;
  logic             wr_elig, rd_elig, grant_wr, grant_rd;
  logic [31:0]      wr_rem, rd_rem, off_nxt;
  logic             frame_end;

  function automatic logic [LEN_W-1:0] need(input logic [31:0] rem);
    return (rem >= 32'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(rem);
  endfunction

  function automatic logic [ADDR_W-1:0] buf_addr(input logic [1:0] idx, input logic [OFF_W-1:0] off);
    logic [63:0] a;
    a = 64'(BASE_ADDR) + 64'(idx) * 64'(BUF_STRIDE) + 64'(off);
    return a[ADDR_W-1:0];
  endfunction

  assign wr_rem    = 32'(FRAME_WORDS) - 32'(wr_off);
  assign rd_rem    = 32'(FRAME_WORDS) - 32'(rd_off);
  assign wr_need   = need(wr_rem);
  assign rd_need   = need(rd_rem);
  assign wr_elig   = enable & ~wr_hold & (32'(wr_level) >= 32'(wr_need));
  assign rd_elig   = enable & (32'(rd_space) >= 32'(rd_need));
  // cmd_write/cmd_len still describe the outstanding burst while in WAIT
  assign off_nxt   = (cmd_write ? 32'(wr_off) : 32'(rd_off)) + 32'(cmd_len);
  assign frame_end = (off_nxt == 32'(FRAME_WORDS));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      IDLE: begin
        grant_wr = wr_elig & (~rd_elig | ~last_wr);
        grant_rd = rd_elig & ~grant_wr;
        if (grant_wr | grant_rd) state_nxt = ISSUE;
      end
      ISSUE:   if (cmd_valid & cmd_ready) state_nxt = WAIT;
      WAIT:    if (burst_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid      <= 1'b0;
      cmd_write      <= 1'b0;
      cmd_addr       <= '0;
      cmd_len        <= '0;
      wr_frame_done  <= 1'b0;
      rd_frame_start <= 1'b0;
      wr_off         <= '0;
      rd_off         <= '0;
      rd_buf         <= 2'd0;
      wr_buf         <= (NUM_BUFS > 1) ? 2'd1 : 2'd0;
      latest         <= 2'd0;
      ready          <= 1'b0;
      wr_hold        <= 1'b0;
      last_wr        <= 1'b0;
    end else begin
      wr_frame_done  <= 1'b0;
      rd_frame_start <= 1'b0;
      if (grant_wr | grant_rd) begin
        cmd_valid <= 1'b1;
        cmd_write <= grant_wr;
        cmd_addr  <= grant_wr ? buf_addr(wr_buf, wr_off) : buf_addr(rd_buf, rd_off);
        cmd_len   <= grant_wr ? wr_need : rd_need;
        last_wr   <= grant_wr;
      end
      if (state == ISSUE && cmd_ready) cmd_valid <= 1'b0;
      if (state == WAIT && burst_done) begin
        if (cmd_write) begin
          wr_off <= frame_end ? '0 : OFF_W'(off_nxt);
          if (frame_end) begin
            wr_frame_done <= 1'b1;
            latest        <= wr_buf;
            ready         <= 1'b1;
            if (NUM_BUFS == 2) begin
              // writer parks on the displayed buffer until the reader swaps away
              wr_buf  <= rd_buf;
              wr_hold <= 1'b1;
            end else if (NUM_BUFS == 3) begin
              // the one index that is neither displayed nor the just-finished frame
              wr_buf <= 2'd3 - rd_buf - wr_buf;
            end
          end
        end else begin
          rd_off <= frame_end ? '0 : OFF_W'(off_nxt);
          if (frame_end) begin
            rd_frame_start <= 1'b1;
            if (ready) begin
              rd_buf  <= latest;
              ready   <= 1'b0;
              wr_hold <= 1'b0;
            end
          end
        end
      end
    end
  end
endmodule
